// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle restoring radix-2 RV32M divide unit using an external adder
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cin,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_cout
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    count;
    logic             is_rem;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] shifted;
    logic             qbit;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Opcode bit 0 set means unsigned; bit 1 set selects the remainder.
    assign signed_op = ~in_op[0];
    assign a_neg     = signed_op & in_a[WIDTH-1];
    assign b_neg     = signed_op & in_b[WIDTH-1];
    assign abs_a     = a_neg ? -in_a : in_a;
    assign abs_b     = b_neg ? -in_b : in_b;
    assign div_zero  = (in_b == '0);
    assign overflow  = signed_op && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);

    // The remainder is effectively WIDTH+1 bits wide: r_reg[msb] is the bit
    // shifted out, and when set the trial subtraction always succeeds.
    assign shifted = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    assign qbit    = r_reg[WIDTH-1] | adder_cout;

    assign adder_a   = (state == CALC) ? shifted : '0;
    assign adder_b   = (state == CALC) ? ~d_reg : '0;
    assign adder_cin = (state == CALC);

    assign q_fix = neg_q ? -q_reg : q_reg;
    assign r_fix = neg_r ? -r_reg : r_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            q_reg      <= '0;
            d_reg      <= '0;
            r_reg      <= '0;
            count      <= '0;
            is_rem     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            out_result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem <= in_op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        q_reg  <= abs_a;
                        d_reg  <= abs_b;
                        r_reg  <= '0;
                        count  <= CW'(WIDTH - 1);
                        if (div_zero) begin
                            out_result <= in_op[1] ? in_a : '1;
                            state      <= DONE;
                        end else if (overflow) begin
                            out_result <= in_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                            state      <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_reg <= qbit ? adder_sum : shifted;
                    q_reg <= {q_reg[WIDTH-2:0], qbit};
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    out_result <= is_rem ? r_fix : q_fix;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - scoreboard bench for iterative_divider with a behavioural adder
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic        adder_cin;
    logic [31:0] adder_sum;
    logic        adder_cout;
    logic [32:0] add_full;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] sb_q[$];

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    iterative_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout)
    );

    assign add_full   = {1'b0, adder_a} + {1'b0, adder_b} + {32'b0, adder_cin};
    assign adder_sum  = add_full[31:0];
    assign adder_cout = add_full[32];

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Returns just after the accepting clock edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        check_eq("in_ready_before_send", {31'b0, in_ready}, 32'd1);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        if (push) sb_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int lat_exp);
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (lat == 2) check_eq({tag, "_cin_in_calc"}, {31'b0, adder_cin}, 32'd1);
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, lat_exp);
    endtask

    task automatic take_result(input string tag);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
            exp = 'x;
        end else begin
            exp = sb_q.pop_front();
        end
        check_eq({tag, "_result"}, out_result, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_valid_dropped"}, {31'b0, out_valid}, 32'd0);
        check_eq({tag, "_adder_idle"}, adder_a | adder_b | {31'b0, adder_cin}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        send(op, a, b, 1'b1);
        wait_valid(tag, exp_latency(op, a, b));
        take_result(tag);
    endtask

    initial begin
        logic [31:0] held;
        int rises;

        #2;
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_result", out_result, 32'd0);
        check_eq("rst_adder", adder_a | adder_b | {31'b0, adder_cin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0);
        run_op("rem_by0", OP_REM, 32'd5, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_ovf_pattern", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int i = 0; i < 16; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case (i % 4)
                0: b = $urandom_range(1, 20);
                1: b = 32'hFFFF_FFFF - $urandom_range(0, 20);
                2: b = $urandom >> $urandom_range(0, 30);
                default: b = $urandom;
            endcase
            run_op("random", op, a, b);
        end

        // Backpressure, then a back-to-back request the cycle after release.
        send(OP_DIVU, 32'd1000, 32'd10, 1'b1);
        wait_valid("bp", 34);
        held = out_result;
        check_eq("bp_result", held, sb_q[0]);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_valid_held", {31'b0, out_valid}, 32'd1);
            check_eq("bp_result_held", out_result, held);
            check_eq("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        end
        void'(sb_q.pop_front());
        @(negedge clk);
        out_ready = 1'b1;
        in_op     = OP_REMU;
        in_a      = 32'd100;
        in_b      = 32'd7;
        in_valid  = 1'b1;
        sb_q.push_back(model(OP_REMU, 32'd100, 32'd7));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("b2b_valid_dropped", {31'b0, out_valid}, 32'd0);
        check_eq("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid("b2b", 34);
        take_result("b2b");

        // Reset at CALC cycle 10.
        send(OP_DIVU, 32'h1234_5678, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_mid_adder", adder_a | adder_b | {31'b0, adder_cin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Flush at CALC cycle 20 of a second op.
        send(OP_DIV, 32'hFEDC_BA98, 32'd77, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("flush_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush coincident with an IDLE accept drops the request.
        @(negedge clk);
        flush    = 1'b1;
        in_op    = OP_DIVU;
        in_a     = 32'd50;
        in_b     = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_accept_in_ready", {31'b0, in_ready}, 32'd1);

        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) rises++;
        end
        check_eq("aborted_no_valid", rises, 32'd0);

        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3);
        check_eq("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
